dffram_rr_arbiter: RTL
======================

// Module: dffram_rr_arbiter
// PURPOSE
//  Two-requester round-robin arbiter sharing one single-port DFFRAM macro (e.g. 128x32, byte WE).
//  Accepts at most one access per cycle, drives the macro's EN0/WE0/A0/Di0 and returns read data
//  to the owning requester with a tracked, fixed latency. Sits between two bus masters and the macro.
// PARAMETERS
//  AW      7   word address width (128 words)
//  WSIZE   4   bytes per word; data width = 8*WSIZE, byte-enable width = WSIZE
//  RD_LAT  1   cycles from accepting edge to Do0 valid (macro read latency, >=1)
// PORTS
//  CLK        in   1          single clock; every register samples on posedge
//  RST        in   1          asynchronous, active-high reset
//  a_req      in   1          requester A access request, held until granted
//  a_we       in   WSIZE      A byte write enables; all-zero = read
//  a_addr     in   AW         A word address
//  a_wdata    in   8*WSIZE    A write data
//  a_gnt      out  1          A accepted this cycle (comb); transfer completes on posedge with a_req&a_gnt
//  a_rvalid   out  1          A read data valid (registered, one-cycle pulse per read)
//  a_rdata    out  8*WSIZE    A read data, meaningful only while a_rvalid
//  b_*        --   --         identical set for requester B
//  ram_en     out  1          to EN0
//  ram_we     out  WSIZE      to WE0
//  ram_a      out  AW         to A0
//  ram_di     out  8*WSIZE    to Di0
//  ram_do     in   8*WSIZE    from Do0
// BEHAVIOUR
//  - Reset (async, while RST=1): priority pointer = A; read-tracking pipe cleared; a_rvalid=b_rvalid=0;
//    a_gnt=b_gnt=0 and ram_en=0, ram_we=0 regardless of requests. ram_a/ram_di = 0.
//  - Arbitration (comb): only one req -> grant it. Both req -> grant the pointer's port.
//    No req -> ram_en=0, ram_we=0, ram_a/ram_di hold the pointer port's inputs (don't care).
//  - Pointer update on posedge: after a grant it points to the other port; unchanged when idle.
//    Hence continuous A+B contention strictly alternates A,B,A,B...; no starvation beyond 1 cycle.
//  - Granted port's we/addr/wdata route to ram_*; ram_en=1. Writes complete at that edge, no response.
//  - Read (we==0) accepted at edge N: owner tag enters an RD_LAT-deep shift pipe; at edge N+RD_LAT
//    the owner's rvalid is registered high for exactly one cycle; x_rdata = ram_do (comb passthrough).
//  - Back-to-back reads pipeline fully: one rvalid per accepted read, in acceptance order, never lost.
//  - Read after write to same address in next cycle returns the new data (macro ordering; no bypass).
//  - Partial write: only bytes with we[i]=1 change; others keep previous contents.
//  - Reset mid-read: pending rvalids are dropped; no rvalid appears after RST deasserts until a new read.
//  - a_rvalid and b_rvalid are never high in the same cycle (single accepted op per cycle).
//  - Requester dropping req before grant is legal; nothing is issued for it.
// TESTING
//  1 A writes 0x00<-AA0055BB, we=1111; A reads 0x00 -> a_rvalid pulse after RD_LAT, a_rdata=AA0055BB, b_rvalid=0.
//  2 Byte mask: A writes 0x02<-00000033 we=0001 over AA0055DD; B reads 0x02 -> b_rdata=AA005533.
//  3 Contention: A and B req every cycle for 8 cycles from reset -> grants A,B,A,B,A,B,A,B; ram_en=1 each cycle.
//  4 Pipelined reads: A reads 0x70,0x71,0x72 back-to-back (data F0F055BB/CC/DD) -> three consecutive
//    a_rvalid pulses with data in order.
//  5 Reset mid-op: A read accepted, RST pulsed before RD_LAT -> no a_rvalid; gnt=0, ram_en=0 during RST.
//  6 Idle: no req for 10 cycles -> ram_en=0, ram_we=0, no rvalid; pointer unchanged (next contention grants same port).

Source files
------------

// File: rtl/dffram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port DFFRAM macro (EN0/WE0/A0/Di0/Do0).
// Latency: grant is combinational in the request cycle; read rvalid is registered RD_LAT edges after the accepting edge.
// Backpressure: a requester holds req until its gnt; the loser of a contention cycle simply waits (at most one cycle).
//
// Ports:
//   CLK, RST                     clock; asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata    requester A access (we all-zero = read)
//   a_gnt                        A accepted this cycle (combinational)
//   a_rvalid/a_rdata             A read response, one-cycle pulse; rdata is Do0 passed through
//   b_*                          identical set for requester B
//   ram_en/ram_we/ram_a/ram_di   macro EN0/WE0/A0/Di0
//   ram_do                       macro Do0

module dffram_rr_arbiter #(
    parameter int AW     = 7,   // word address width
    parameter int WSIZE  = 4,   // bytes per word
    parameter int RD_LAT = 1    // macro read latency in cycles, must be >= 1
) (
    input  logic                 CLK,
    input  logic                 RST,

    input  logic                 a_req,
    input  logic [WSIZE-1:0]     a_we,
    input  logic [AW-1:0]        a_addr,
    input  logic [8*WSIZE-1:0]   a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [8*WSIZE-1:0]   a_rdata,

    input  logic                 b_req,
    input  logic [WSIZE-1:0]     b_we,
    input  logic [AW-1:0]        b_addr,
    input  logic [8*WSIZE-1:0]   b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [8*WSIZE-1:0]   b_rdata,

    output logic                 ram_en,
    output logic [WSIZE-1:0]     ram_we,
    output logic [AW-1:0]        ram_a,
    output logic [8*WSIZE-1:0]   ram_di,
    input  logic [8*WSIZE-1:0]   ram_do
);

    localparam int DW = 8 * WSIZE;

    // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
    logic ptr_b;

    // Arbitration results for this cycle.
    logic arb_a;
    logic arb_b;
    logic sel_b;        // which port's fields drive the macro pins
    logic rd_issue;     // an accepted access this cycle is a read

    // Read tracking pipe: one valid/owner slot per cycle of macro latency.
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_own;   // 1 = read belongs to B

    logic a_rvalid_q;
    logic b_rvalid_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // A wins when it is the only requester or when the pointer favours it;
    // otherwise any B request wins. Reset masks all grants so the macro is
    // never enabled while the pipe is being cleared.
    always_comb begin
        arb_a = 1'b0;
        arb_b = 1'b0;
        if (!RST) begin
            if (a_req && (!b_req || !ptr_b)) begin
                arb_a = 1'b1;
            end else if (b_req) begin
                arb_b = 1'b1;
            end
        end
    end

    // With no grant the address/data mux follows the pointer; the values
    // are don't-care because EN0 is low.
    always_comb begin
        sel_b = ptr_b;
        if (arb_a) begin
            sel_b = 1'b0;
        end else if (arb_b) begin
            sel_b = 1'b1;
        end
    end

    assign a_gnt = arb_a;
    assign b_gnt = arb_b;

    // ------------------------------------------------------------------
    // Macro pin drive
    // ------------------------------------------------------------------
    always_comb begin
        ram_en = arb_a | arb_b;
        ram_we = '0;
        ram_a  = '0;
        ram_di = '0;
        if (!RST) begin
            ram_a  = sel_b ? b_addr  : a_addr;
            ram_di = sel_b ? b_wdata : a_wdata;
            if (ram_en) begin
                ram_we = sel_b ? b_we : a_we;
            end
        end
    end

    assign rd_issue = ram_en && (ram_we == '0);

    // ------------------------------------------------------------------
    // Pointer: after any grant, hand priority to the other port; an idle
    // cycle leaves it alone so fairness survives gaps in traffic.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_b <= 1'b0;
        end else if (ram_en) begin
            ptr_b <= arb_a;
        end
    end

    // ------------------------------------------------------------------
    // Read tracking. The tag enters slot 0 at the accepting edge and the
    // response strobe is registered from the last slot, so it rises at the
    // edge RD_LAT after acceptance, the same edge the macro presents Do0.
    // Only one access is accepted per cycle, so the two strobes are
    // mutually exclusive by construction.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe_vld <= '0;
            pipe_own <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_own[0] <= sel_b;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= pipe_vld[RD_LAT-1] & ~pipe_own[RD_LAT-1];
            b_rvalid_q <= pipe_vld[RD_LAT-1] &  pipe_own[RD_LAT-1];
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;

    // Do0 is shared; each requester qualifies it with its own rvalid.
    assign a_rdata = ram_do[DW-1:0];
    assign b_rdata = ram_do[DW-1:0];

endmodule
